fp8_dot_seq: RTL and testbench

Initiator-side sequencer for the team's FP8 MAC start/done interface. Accepts a dot-product command of N operand pairs and pulls pairs from an operand stream. Clears the MAC accumulator, issues one MAC start per pair, waits for each done, and returns the final 8-bit accumulator on a valid/ready result port. Sits between the operand buffers/host and one FP8 MAC processing element.

---
 rtl/fp8_pkg.sv | 14 +
 rtl/fp8_seq_watchdog.sv | 29 ++
 rtl/fp8_dot_seq.sv | 143 ++++++++++++++
 tb/tb_fp8_dot_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 dot-product sequencer: FSM encoding and FP8 constants.
package fp8_pkg;

   localparam int FP8_W = 8;
   localparam logic [FP8_W-1:0] FP8_POS_ZERO = 8'h00;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_FETCH  = 3'd2;
   localparam logic [2:0] ST_ISSUE  = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_RESULT = 3'd5;

endpackage

// File: rtl/fp8_seq_watchdog.sv
// Cycle timer for the MAC wait phase: cleared on issue, counts while enabled,
// flags expiry on the TIMEOUT-th enabled cycle.
module fp8_seq_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] timer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (clr) begin
         timer <= '0;
      end else if (en) begin
         timer <= timer + TW'(1);
      end
   end

   assign expire = en && (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fp8_dot_seq.sv
// Initiator-side sequencer for the FP8 MAC start/done interface: clears the MAC,
// streams N operand pairs through it one at a time and returns the final accumulator.
module fp8_dot_seq
   import fp8_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [FP8_W-1:0] op_a,
   input  logic [FP8_W-1:0] op_b,
   output logic             mac_rst_n,
   output logic             mac_start,
   output logic [FP8_W-1:0] mac_a,
   output logic [FP8_W-1:0] mac_b,
   input  logic             mac_done,
   input  logic [FP8_W-1:0] mac_acc,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [FP8_W-1:0] res_data,
   output logic             res_err,
   output logic [LEN_W-1:0] res_count
);

   logic [2:0]       state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_inc;
   logic [LEN_W-1:0] len_clamped;
   logic             expire;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(MAX_LEN)) begin
         return LEN_W'(MAX_LEN);
      end
      return len;
   endfunction

   assign len_clamped = clamp_len(cmd_len);
   assign cnt_inc     = cnt + LEN_W'(1);

   assign cmd_ready = (state == ST_IDLE);
   assign op_ready  = (state == ST_FETCH);
   // Reset reaches the MAC combinationally so a mid-command reset also clears it.
   assign mac_rst_n = ~(rst | (state == ST_CLEAR));

   fp8_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == ST_ISSUE),
      .en     (state == ST_WAIT),
      .expire (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         cnt       <= '0;
         mac_start <= 1'b0;
         mac_a     <= FP8_POS_ZERO;
         mac_b     <= FP8_POS_ZERO;
         res_valid <= 1'b0;
         res_data  <= FP8_POS_ZERO;
         res_err   <= 1'b0;
         res_count <= '0;
      end else begin
         mac_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  len_q <= len_clamped;
                  if (len_clamped == '0) begin
                     res_data  <= FP8_POS_ZERO;
                     res_count <= '0;
                     res_err   <= 1'b0;
                     res_valid <= 1'b1;
                     state     <= ST_RESULT;
                  end else begin
                     state <= ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               // Drop any result left from the previous command so a first-pair abort reports +0.
               cnt      <= '0;
               res_data <= FP8_POS_ZERO;
               state    <= ST_FETCH;
            end
            ST_FETCH: begin
               if (op_valid) begin
                  mac_a     <= op_a;
                  mac_b     <= op_b;
                  mac_start <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Done takes priority over a coincident timeout.
               if (mac_done) begin
                  cnt      <= cnt_inc;
                  res_data <= mac_acc;
                  if (cnt_inc == len_q) begin
                     res_count <= len_q;
                     res_err   <= 1'b0;
                     res_valid <= 1'b1;
                     state     <= ST_RESULT;
                  end else begin
                     state <= ST_FETCH;
                  end
               end else if (expire) begin
                  res_count <= cnt;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp8_dot_seq.sv
// Directed bench for fp8_dot_seq with a 3-cycle counting MAC stub.
module tb_fp8_dot_seq;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [7:0]       op_a = 8'h00;
   logic [7:0]       op_b = 8'h00;
   logic             mac_rst_n;
   logic             mac_start;
   logic [7:0]       mac_a;
   logic [7:0]       mac_b;
   logic             mac_done;
   logic [7:0]       mac_acc;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [7:0]       res_data;
   logic             res_err;
   logic [LEN_W-1:0] res_count;

   int n_checks = 0;
   int n_errors = 0;

   fp8_dot_seq #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .mac_rst_n (mac_rst_n),
      .mac_start (mac_start),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_done  (mac_done),
      .mac_acc   (mac_acc),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .res_count (res_count)
   );

   always #5 clk = ~clk;

   // MAC stub: done 3 cycles after start, accumulator counts starts, cleared by mac_rst_n.
   logic [2:0] stub_sr = '0;
   logic [7:0] stub_acc = '0;
   int         stub_starts = 0;
   int         hang_idx = -1;

   always @(posedge clk) begin
      if (!mac_rst_n) begin
         stub_sr     <= '0;
         stub_acc    <= '0;
         stub_starts <= 0;
      end else begin
         stub_sr <= {stub_sr[1:0], mac_start && (stub_starts != hang_idx)};
         if (mac_start) begin
            stub_acc    <= stub_acc + 8'd1;
            stub_starts <= stub_starts + 1;
         end
      end
   end

   assign mac_done = stub_sr[2];
   assign mac_acc  = stub_acc;

   // Interface monitor, sampled mid-cycle.
   int         cyc = 0;
   int         n_rst_low, n_start, n_start_hi, n_done;
   int         start_cyc [32];
   logic [7:0] start_a [32];
   logic [7:0] done_a [32];
   logic [7:0] done_b [32];
   logic       start_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst && !mac_rst_n) n_rst_low++;
      if (mac_start) begin
         n_start_hi++;
         if (!start_prev && n_start < 32) begin
            start_cyc[n_start] = cyc;
            start_a[n_start]   = mac_a;
            n_start++;
         end
      end
      start_prev = mac_start;
      if (mac_done && n_done < 32) begin
         done_a[n_done] = mac_a;
         done_b[n_done] = mac_b;
         n_done++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      n_rst_low  = 0;
      n_start    = 0;
      n_start_hi = 0;
      n_done     = 0;
   endtask

   task automatic send_cmd(input int len);
      int g = 0;
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      while (!cmd_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
   endtask

   task automatic feed(input int n, input int stall_pair, input int stall);
      int g;
      for (int p = 0; p < n; p++) begin
         op_a = 8'h30 + 8'(8 * p);
         op_b = 8'h38 + 8'(8 * p);
         if (p == stall_pair) begin
            op_valid = 1'b0;
            g = 0;
            while (!op_ready && g < 300) begin
               @(negedge clk);
               g++;
            end
            repeat (stall) @(negedge clk);
         end
         op_valid = 1'b1;
         g = 0;
         while (!op_ready && g < 300) begin
            @(negedge clk);
            g++;
         end
         if (g >= 300) begin
            chk("op_handshake", {31'd0, op_ready}, 32'd1);
            op_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      op_valid = 1'b0;
   endtask

   int res_cyc;

   task automatic wait_res();
      int g = 0;
      @(negedge clk);
      while (!res_valid && g < 400) begin
         @(negedge clk);
         g++;
      end
      res_cyc = cyc;
      chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("res_valid_drop", {31'd0, res_valid}, 32'd0);
      chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      clr_mon();
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_mac_start", {31'd0, mac_start}, 32'd0);
      chk("rst_mac_rst_n", {31'd0, mac_rst_n}, 32'd0);
      chk("rst_res_data", {24'd0, res_data}, 32'h00);
      chk("rst_res_count", {27'd0, res_count}, 32'd0);
      chk("rst_res_err", {31'd0, res_err}, 32'd0);
      chk("rst_mac_ab", {16'd0, mac_a, mac_b}, 32'h0000);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_mac_rst_n", {31'd0, mac_rst_n}, 32'd1);
      chk("idle_op_ready", {31'd0, op_ready}, 32'd0);

      // Four pairs, operands always available.
      clr_mon();
      fork
         send_cmd(4);
         feed(4, -1, 0);
      join
      wait_res();
      chk("t1_clear_cycles", n_rst_low, 1);
      chk("t1_start_pulses", n_start, 4);
      chk("t1_start_width", n_start_hi, 4);
      chk("t1_start_gap", start_cyc[1] - start_cyc[0], 5);
      chk("t1_res_data", {24'd0, res_data}, 32'h04);
      chk("t1_res_count", {27'd0, res_count}, 32'd4);
      chk("t1_res_err", {31'd0, res_err}, 32'd0);
      take_res();

      // Zero-length command.
      clr_mon();
      send_cmd(0);
      @(negedge clk);
      chk("t2_res_valid", {31'd0, res_valid}, 32'd1);
      chk("t2_res_data", {24'd0, res_data}, 32'h00);
      chk("t2_res_count", {27'd0, res_count}, 32'd0);
      chk("t2_res_err", {31'd0, res_err}, 32'd0);
      chk("t2_no_clear", n_rst_low, 0);
      chk("t2_no_start", n_start, 0);
      take_res();

      // Operand stall of 5 cycles before the second pair.
      clr_mon();
      fork
         send_cmd(3);
         feed(3, 1, 5);
      join
      wait_res();
      chk("t3_start_pulses", n_start, 3);
      chk("t3_gap_stalled", start_cyc[1] - start_cyc[0], 10);
      chk("t3_gap_normal", start_cyc[2] - start_cyc[1], 5);
      chk("t3_start_a", {24'd0, start_a[1]}, 32'h38);
      chk("t3_done_a", {24'd0, done_a[1]}, 32'h38);
      chk("t3_done_b", {24'd0, done_b[1]}, 32'h40);
      chk("t3_res_data", {24'd0, res_data}, 32'h03);
      chk("t3_res_count", {27'd0, res_count}, 32'd3);
      take_res();

      // MAC never answers pair 2: timeout abort, then a stalled result handshake.
      clr_mon();
      hang_idx = 1;
      fork
         send_cmd(3);
         feed(2, -1, 0);
      join
      wait_res();
      chk("t4_abort_latency", res_cyc - start_cyc[1], TIMEOUT + 1);
      chk("t4_res_err", {31'd0, res_err}, 32'd1);
      chk("t4_res_count", {27'd0, res_count}, 32'd1);
      chk("t4_res_data", {24'd0, res_data}, 32'h01);
      chk("t4_start_pulses", n_start, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", {31'd0, res_valid}, 32'd1);
         chk("t5_hold_data", {24'd0, res_data}, 32'h01);
         chk("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      take_res();
      hang_idx = -1;

      // Oversized length is clamped to MAX_LEN.
      clr_mon();
      fork
         send_cmd(20);
         feed(MAX_LEN, -1, 0);
      join
      wait_res();
      chk("clamp_start_pulses", n_start, MAX_LEN);
      chk("clamp_res_data", {24'd0, res_data}, 32'h10);
      chk("clamp_res_count", {27'd0, res_count}, 32'd16);
      take_res();

      // Reset while waiting on pair 2, then a fresh command.
      clr_mon();
      fork
         send_cmd(3);
         feed(2, -1, 0);
      join
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_mac_rst_n", {31'd0, mac_rst_n}, 32'd0);
      chk("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("t6_idle_mac_rst_n", {31'd0, mac_rst_n}, 32'd1);
      clr_mon();
      fork
         send_cmd(2);
         feed(2, -1, 0);
      join
      wait_res();
      chk("t6_res_data", {24'd0, res_data}, 32'h02);
      chk("t6_res_count", {27'd0, res_count}, 32'd2);
      chk("t6_res_err", {31'd0, res_err}, 32'd0);
      take_res();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
